// File: rtl/keypad_emulator_if.sv
// Key-code handshake between a key producer and the keypad emulator.
// Transfer occurs on a slowclk edge where key_valid and key_ready are both high.
interface keypad_emulator_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_emulator.sv
// Synthetic 4x4 key matrix: replays queued key codes as timed presses on the
// active-low row lines, answering the scanner's column drive combinationally.
module keypad_emulator #(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned GAP_CYCLES  = 8,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                slowclk,
  input  logic                reset,
  keypad_emulator_if.slave    kbd,
  input  logic [3:0]          cols,
  output logic [3:0]          rows,
  output logic                pressing,
  output logic [3:0]          cur_key,
  output logic                key_done,
  output logic                busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DepthCnt = (AW + 1)'(FIFO_DEPTH);
  localparam logic [7:0]  HoldLoad = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]  GapLoad  = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPress, StRelease} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  cur_q, cur_d;
  logic        done_q, done_d;

  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          full, empty, push, pop;

  assign full          = (count_q == DepthCnt);
  assign empty         = (count_q == '0);
  assign kbd.key_ready = !full;
  assign push          = kbd.key_valid && !full;

  // Queue storage carries no reset; only pointers and occupancy matter.
  always_ff @(posedge slowclk) begin
    if (push) begin
      mem_q[wptr_q] <= kbd.key_code;
    end
  end

  always_ff @(posedge slowclk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge slowclk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cur_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          cur_d   = mem_q[rptr_q];
          cnt_d   = HoldLoad;
          state_d = StPress;
        end
      end
      StPress: begin
        if (cnt_q == '0) begin
          cnt_d   = GapLoad;
          state_d = StRelease;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRelease: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Matrix position of the current key: column bit driven low, row bit pulled low.
  logic [1:0] key_col, key_row;
  always_comb begin
    key_col = 2'd0;
    key_row = 2'd0;
    unique case (cur_q)
      4'h0: begin key_col = 2'd1; key_row = 2'd0; end
      4'h1: begin key_col = 2'd0; key_row = 2'd3; end
      4'h2: begin key_col = 2'd1; key_row = 2'd3; end
      4'h3: begin key_col = 2'd2; key_row = 2'd3; end
      4'h4: begin key_col = 2'd0; key_row = 2'd2; end
      4'h5: begin key_col = 2'd1; key_row = 2'd2; end
      4'h6: begin key_col = 2'd2; key_row = 2'd2; end
      4'h7: begin key_col = 2'd0; key_row = 2'd1; end
      4'h8: begin key_col = 2'd1; key_row = 2'd1; end
      4'h9: begin key_col = 2'd2; key_row = 2'd1; end
      4'hA: begin key_col = 2'd0; key_row = 2'd0; end
      4'hB: begin key_col = 2'd2; key_row = 2'd0; end
      4'hC: begin key_col = 2'd3; key_row = 2'd3; end
      4'hD: begin key_col = 2'd3; key_row = 2'd2; end
      4'hE: begin key_col = 2'd3; key_row = 2'd1; end
      default: begin key_col = 2'd3; key_row = 2'd0; end
    endcase
  end

  assign pressing = (state_q == StPress);
  assign cur_key  = cur_q;
  assign key_done = done_q;
  assign busy     = (state_q != StIdle) || !empty;

  always_comb begin
    rows = 4'hF;
    if (pressing && !cols[key_col]) begin
      rows[key_row] = 1'b0;
    end
  end

endmodule
